alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, registered successor to the 4-bit combinational ALU. It accepts an operand pair and opcode through a valid/ready input handshake and computes add, sub, negate, logic, compare, shift and an optional iterative multiply. It returns flagged results through a valid/ready output handshake. It sits between the operand-select logic and the result/flag display path; all outputs are registered.

## Interface
- `WIDTH`, default 8: operand/result width. Power of two, ≥4.
- `SHW`, default `$clog2(WIDTH)`: shift-amount width. Derived; do not override.

Ports:
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `in_valid`  in  1  request present
- `in_ready`  out  1  request accepted when `in_valid && in_ready` at the clock edge
- `a`  in  WIDTH  operand A
- `b`  in  WIDTH  operand B, or shift amount in `b[SHW-1:0]`
- `opcode`  in  4  operation select
- `out_valid`  out  1  result present
- `out_ready`  in  1  result consumed when `out_valid && out_ready` at the clock edge
- `out_s`  out  WIDTH  result word
- `out_c`  out  1  carry / shifted-out bit
- `out`  out  1  compare result
- `overflow`  out  1  signed overflow / product overflow

## Operation
- FSM states:
  - IDLE: no result held.
  - BUSY: multiply iterating.
  - DONE: result held, `out_valid`=1.
- Accept a request in IDLE, or in DONE when `out_ready`=1 (back-to-back).
  - Single-cycle op: go to DONE.
  - Multiply: go to BUSY.
- BUSY → DONE after WIDTH iterations.
- DONE → IDLE when consumed and no new request is accepted.
- Inputs are captured at acceptance; later input changes have no effect.
- Flags not listed for an opcode are 0.
- Opcodes:
  - 0000 add: `{out_c,out_s}=a+b`; `overflow` = signed overflow.
  - 0001 sub: `out_s=a-b`; `out_c` = carry of `a+~b+1` (1 means no borrow); `overflow` = signed overflow.
  - 0010 neg: `out_s=-a`; `overflow`=1 iff `a`=100…0.
  - 0011 and, 0100 or, 0101 xor: `out_s` = bitwise result.
  - 0110 unsigned less: `out`=(a<b).
  - 0111 equal: `out`=(a==b).
  - 1000 shift left logical; 1001 shift right logical; 1010 shift right arithmetic.
    - Amount is `b[SHW-1:0]`.
    - `out_c` = last bit shifted out; 0 when the amount is 0.
  - 1011 multiply, unsigned: `out_s` = low WIDTH bits of the product; `overflow`=1 iff the high half ≠ 0. Shift-add, one partial product per cycle.
  - 1100 signed less: `out`=($signed(a)<$signed(b)).
  - 1101–1111: `out_s`=0, all flags 0, single-cycle.

## Timing
- Reset:
  - FSM goes to IDLE.
  - `out_valid`=0, `out_s`=0, `out_c`=0, `out`=0, `overflow`=0.
  - `in_ready`=1 after release.
- Single-cycle latency: request accepted at edge N → `out_valid`=1 after edge N.
- Multiply latency: result valid after edge N+WIDTH.
- `in_ready` is combinational from state and `out_ready`: 1 in IDLE, 0 in BUSY, `out_ready` in DONE.
- Throughput of single-cycle ops is one per cycle while `out_ready`=1.
- Back-pressure: while `out_valid && !out_ready`, all outputs hold stable.
- Simultaneous consume + accept in DONE:
  - Single-cycle request: the new result replaces the old next cycle and `out_valid` stays 1.
  - Multiply request: `out_valid` drops to 0 during BUSY.
- `rst_n` low mid-multiply or mid-hold aborts immediately; the partial result is discarded.

## Configuration
- `ALU_SEQ_MUL_EN` defined: multiply datapath and BUSY state are present; opcode 1011 behaves as above.
- `ALU_SEQ_MUL_EN` undefined:
  - No multiplier registers.
  - Opcode 1011 is treated as undefined: single-cycle, `out_s`=0, flags 0.
  - `in_ready` never 0 from BUSY.

## Test plan
- WIDTH=8, add `a`=8'h7F, `b`=8'h01 → `out_s`=8'h80, `out_c`=0, `overflow`=1, one cycle after acceptance.
- Sub `a`=8'h03, `b`=8'h05 → `out_s`=8'hFE, `out_c`=0, `overflow`=0. Then unsigned less on the same operands → `out`=1. Signed less with `a`=8'hFF, `b`=8'h01 → `out`=1.
- Shift right arithmetic `a`=8'h90, `b`=3 → `out_s`=8'hF2, `out_c`=0. Shift left logical `a`=8'h81, `b`=1 → `out_s`=8'h02, `out_c`=1.
- With `ALU_SEQ_MUL_EN`: multiply `a`=8'h10, `b`=8'h11 → `out_s`=8'h10, `overflow`=1, `out_valid` exactly 8 cycles after acceptance, `in_ready`=0 meanwhile. Without the macro: same stimulus → `out_s`=0 after one cycle.
- Back-pressure: hold `out_ready`=0 for 5 cycles with a new request presented → result and flags stable, `in_ready`=0. Then stream 4 adds with `out_ready`=1 → 4 consecutive valid results, no gaps.
- Assert `rst_n`=0 three cycles into a multiply → `out_valid`=0 and all outputs 0 immediately. After release, add 2+3 → `out_s`=5.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshakes on both sides; optional iterative multiply (`ALU_SEQ_MUL_EN`).
// Latency: single-cycle ops valid the cycle after acceptance; multiply valid WIDTH cycles after acceptance.
// Backpressure: a held result and its flags stay stable while out_ready=0; in_ready follows out_ready in DONE, 0 in BUSY.
//
// Ports:
//   clk, rst_n                    : rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready           : request handshake; a, b, opcode are captured on acceptance
//   a, b, opcode                  : operands (b[SHW-1:0] is the shift amount) and operation select
//   out_valid / out_ready         : result handshake
//   out_s, out_c, out, overflow   : result word, carry/shifted-out bit, compare result, overflow flag
module alu_seq #(
   parameter int WIDTH = 8,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       opcode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_s,
   output logic             out_c,
   output logic             out,
   output logic             overflow
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] DONE = 2'd2;
`ifdef ALU_SEQ_MUL_EN
   localparam logic [1:0] BUSY = 2'd1;
`endif

   logic [1:0] state;
   logic       accept;

   // Accepting while DONE is only possible when the held result is being
   // consumed on the same edge, which gives back-to-back throughput.
   assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
   assign accept   = in_valid && in_ready;

   // ---------------------------------------------------------------
   // Single-cycle datapath
   // ---------------------------------------------------------------
   logic [SHW-1:0] amt;
   logic [WIDTH:0] add_w, sub_w, sll_w, srl_w, sra_w;
   logic [WIDTH-1:0] r_s;
   logic             r_c, r_o, r_ov;

   assign amt   = b[SHW-1:0];
   assign add_w = {1'b0, a} + {1'b0, b};
   assign sub_w = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
   // Each shift carries one guard bit so the last bit shifted out lands in a
   // fixed position; with amount 0 the guard bit stays 0.
   assign sll_w = {1'b0, a} << amt;
   assign srl_w = {a, 1'b0} >> amt;
   assign sra_w = $signed({a, 1'b0}) >>> amt;

   always_comb begin
      r_s  = '0;
      r_c  = 1'b0;
      r_o  = 1'b0;
      r_ov = 1'b0;
      case (opcode)
         4'b0000: begin
            r_s  = add_w[WIDTH-1:0];
            r_c  = add_w[WIDTH];
            r_ov = (a[WIDTH-1] == b[WIDTH-1]) && (add_w[WIDTH-1] != a[WIDTH-1]);
         end
         4'b0001: begin
            r_s  = sub_w[WIDTH-1:0];
            r_c  = sub_w[WIDTH];
            r_ov = (a[WIDTH-1] != b[WIDTH-1]) && (sub_w[WIDTH-1] != a[WIDTH-1]);
         end
         4'b0010: begin
            r_s  = -a;
            r_ov = (a == {1'b1, {(WIDTH-1){1'b0}}});
         end
         4'b0011: r_s = a & b;
         4'b0100: r_s = a | b;
         4'b0101: r_s = a ^ b;
         4'b0110: r_o = (a < b);
         4'b0111: r_o = (a == b);
         4'b1000: begin
            r_s = sll_w[WIDTH-1:0];
            r_c = sll_w[WIDTH];
         end
         4'b1001: begin
            r_s = srl_w[WIDTH:1];
            r_c = srl_w[0];
         end
         4'b1010: begin
            r_s = sra_w[WIDTH:1];
            r_c = sra_w[0];
         end
         4'b1100: r_o = ($signed(a) < $signed(b));
         // 1011 lands here too: it is either handled by the multiplier or
         // treated as an undefined opcode.
         default: ;
      endcase
   end

`ifdef ALU_SEQ_MUL_EN
   // ---------------------------------------------------------------
   // Shift-add multiplier: prod starts as {0, b}; each step adds the
   // multiplicand into the upper half when the current multiplier bit is
   // set, then shifts right. After WIDTH steps prod holds a*b.
   // ---------------------------------------------------------------
   logic [WIDTH-1:0]   mcand;
   logic [2*WIDTH-1:0] prod, prod_nx;
   logic [SHW-1:0]     cnt;
   logic [WIDTH:0]     psum;
   logic               is_mul;

   assign is_mul  = (opcode == 4'b1011);
   assign psum    = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
   assign prod_nx = {psum, prod[WIDTH-1:1]};
`endif

   // ---------------------------------------------------------------
   // Control and output registers
   // ---------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         out_s     <= '0;
         out_c     <= 1'b0;
         out       <= 1'b0;
         overflow  <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
         mcand     <= '0;
         prod      <= '0;
         cnt       <= '0;
`endif
      end else if (accept) begin
`ifdef ALU_SEQ_MUL_EN
         if (is_mul) begin
            state     <= BUSY;
            out_valid <= 1'b0;
            mcand     <= a;
            prod      <= {{WIDTH{1'b0}}, b};
            cnt       <= '0;
         end else
`endif
         begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_s     <= r_s;
            out_c     <= r_c;
            out       <= r_o;
            overflow  <= r_ov;
         end
`ifdef ALU_SEQ_MUL_EN
      end else if (state == BUSY) begin
         prod <= prod_nx;
         cnt  <= cnt + SHW'(1);
         if (cnt == SHW'(WIDTH - 1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_s     <= prod_nx[WIDTH-1:0];
            out_c     <= 1'b0;
            out       <= 1'b0;
            overflow  <= |prod_nx[2*WIDTH-1:WIDTH];
         end
`endif
      end else if ((state == DONE) && out_ready) begin
         // Consumed with no new request: drop back to IDLE. Result bits are
         // left as they are; out_valid=0 marks them stale.
         state     <= IDLE;
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: randomized and directed stimulus for alu_seq, checked each cycle against a behavioural model.
// Latency: the model predicts the cycle each result must appear; single-cycle ops 1 edge, multiply WIDTH edges.
// Backpressure: out_ready is randomized; held results must remain identical to the model until consumed.
module tb_alu_seq;

   localparam int W = 8;
`ifdef ALU_SEQ_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a, b;
   logic [3:0]   opcode;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_s;
   logic         out_c, out, overflow;

   alu_seq #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .opcode(opcode),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_s(out_s), .out_c(out_c), .out(out), .overflow(overflow)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [7:0] s;
      logic       c;
      logic       o;
      logic       ov;
      int         due;
   } exp_t;

   exp_t sbq[$];
   int   n_pass = 0;
   int   n_total = 0;
   bit   rand_rdy = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_total++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, expv);
   endtask

   // Reference behaviour from plain integer arithmetic.
   function automatic exp_t model(input logic [7:0] a_i, input logic [7:0] b_i, input logic [3:0] op_i);
      exp_t e;
      int ua, ub, sa, sb, amt, r;
      ua = a_i; ub = b_i;
      sa = $signed(a_i); sb = $signed(b_i);
      amt = b_i[2:0];
      e.s = 8'h00; e.c = 1'b0; e.o = 1'b0; e.ov = 1'b0; e.due = 0;
      case (op_i)
         4'd0: begin r = ua + ub; e.s = r[7:0]; e.c = r[8]; e.ov = (sa + sb > 127) || (sa + sb < -128); end
         4'd1: begin r = ua - ub; e.s = r[7:0]; e.c = (ua >= ub); e.ov = (sa - sb > 127) || (sa - sb < -128); end
         4'd2: begin r = -ua; e.s = r[7:0]; e.ov = (ua == 128); end
         4'd3: e.s = a_i & b_i;
         4'd4: e.s = a_i | b_i;
         4'd5: e.s = a_i ^ b_i;
         4'd6: e.o = (ua < ub);
         4'd7: e.o = (ua == ub);
         4'd8: begin r = ua << amt; e.s = r[7:0]; e.c = (amt != 0) ? r[8] : 1'b0; end
         4'd9: begin
            r = ua >> amt; e.s = r[7:0];
            if (amt != 0) begin r = ua >> (amt - 1); e.c = r[0]; end
         end
         4'd10: begin
            r = sa >>> amt; e.s = r[7:0];
            if (amt != 0) begin r = sa >>> (amt - 1); e.c = r[0]; end
         end
         4'd11: begin
            r = ua * ub;
            e.s  = MUL_EN ? r[7:0] : 8'h00;
            e.ov = MUL_EN ? (r > 255) : 1'b0;
         end
         4'd12: e.o = (sa < sb);
         default: ;
      endcase
      return e;
   endfunction

   function automatic int lat_of(input logic [3:0] op_i);
      return (MUL_EN && op_i == 4'd11) ? W : 0;
   endfunction

   // Per-cycle compare against the scoreboard.
   always @(negedge clk) begin : cmp
      exp_t e;
      bit hold, busy;
      logic exp_rdy;
      if (!rst_n) begin
         chk("reset_outputs", {out_valid, out_s, out_c, out, overflow}, 32'h0);
      end else begin
         hold = (sbq.size() > 0) && (sbq[0].due <= cyc);
         busy = (sbq.size() > 0) && (sbq[0].due > cyc);
         exp_rdy = busy ? 1'b0 : (hold ? out_ready : 1'b1);
         chk("out_valid", out_valid, hold);
         chk("in_ready", in_ready, exp_rdy);
         if (hold && out_valid) begin
            chk("result{s,c,out,ov}", {out_s, out_c, out, overflow},
                {sbq[0].s, sbq[0].c, sbq[0].o, sbq[0].ov});
            if (out_ready) void'(sbq.pop_front());
         end
         if (in_valid && in_ready) begin
            e = model(a, b, opcode);
            e.due = cyc + 1 + lat_of(opcode);
            sbq.push_back(e);
         end
      end
   end

   always @(posedge clk) begin
      if (rand_rdy) begin
         #1;
         out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   // Present a request and hold it until accepted; returns 1 time unit after the accepting edge.
   task automatic send(input logic [7:0] av, input logic [7:0] bv, input logic [3:0] ov);
      int budget;
      budget = 40;
      a = av; b = bv; opcode = ov; in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && budget > 0) begin
         budget--;
         @(negedge clk);
      end
      if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a = 8'($urandom); b = 8'($urandom); opcode = 4'($urandom);
   endtask

   // Directed transaction with literal expectations; edges counted after the accepting edge.
   task automatic dir(input string nm, input logic [7:0] av, input logic [7:0] bv, input logic [3:0] ov,
                      input logic [7:0] es, input logic ec, input logic eo, input logic eov, input int elat);
      int t0, budget;
      send(av, bv, ov);
      t0 = cyc;
      budget = 20;
      @(negedge clk);
      while (!out_valid && budget > 0) begin
         budget--;
         @(negedge clk);
      end
      chk({nm, "_latency"}, cyc - t0, elat);
      chk({nm, "_out_s"}, out_s, es);
      chk({nm, "_flags{c,out,ov}"}, {out_c, out, overflow}, {ec, eo, eov});
      @(posedge clk);
      #1;
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("%0d/%0d checks passed", n_pass, n_total + 1);
      $fatal(1, "timeout");
   end

   initial begin : main
      exp_t e;
      int vcount;
      logic [7:0] specials [4];
      specials[0] = 8'h80; specials[1] = 8'h7F; specials[2] = 8'hFF; specials[3] = 8'h00;

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; opcode = '0;

      // Model pins: hand-computed values.
      e = model(8'h7F, 8'h01, 4'd0);  chk("model_add", {e.s, e.c, e.o, e.ov}, {8'h80, 3'b001});
      e = model(8'h03, 8'h05, 4'd1);  chk("model_sub", {e.s, e.c, e.o, e.ov}, {8'hFE, 3'b000});
      e = model(8'h03, 8'h05, 4'd6);  chk("model_ult", {e.s, e.c, e.o, e.ov}, {8'h00, 3'b010});
      e = model(8'hFF, 8'h01, 4'd12); chk("model_slt", {e.s, e.c, e.o, e.ov}, {8'h00, 3'b010});
      e = model(8'h90, 8'h03, 4'd10); chk("model_sra", {e.s, e.c, e.o, e.ov}, {8'hF2, 3'b000});
      e = model(8'h81, 8'h01, 4'd8);  chk("model_sll", {e.s, e.c, e.o, e.ov}, {8'h02, 3'b100});
      e = model(8'h10, 8'h11, 4'd11);
      chk("model_mul", {e.s, e.c, e.o, e.ov}, MUL_EN ? {8'h10, 3'b001} : {8'h00, 3'b000});

      // Reset state.
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_out_valid", out_valid, 1'b0);
      chk("reset_out_s", out_s, 8'h00);
      chk("reset_flags{c,out,ov}", {out_c, out, overflow}, 3'b000);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("in_ready_after_reset", in_ready, 1'b1);
      @(posedge clk); #1;
      out_ready = 1'b1;

      // Directed cases.
      dir("add_7f_01", 8'h7F, 8'h01, 4'd0, 8'h80, 1'b0, 1'b0, 1'b1, 0);
      dir("sub_03_05", 8'h03, 8'h05, 4'd1, 8'hFE, 1'b0, 1'b0, 1'b0, 0);
      dir("ult_03_05", 8'h03, 8'h05, 4'd6, 8'h00, 1'b0, 1'b1, 1'b0, 0);
      dir("slt_ff_01", 8'hFF, 8'h01, 4'd12, 8'h00, 1'b0, 1'b1, 1'b0, 0);
      dir("sra_90_3", 8'h90, 8'h03, 4'd10, 8'hF2, 1'b0, 1'b0, 1'b0, 0);
      dir("sll_81_1", 8'h81, 8'h01, 4'd8, 8'h02, 1'b1, 1'b0, 1'b0, 0);
      dir("neg_80", 8'h80, 8'h00, 4'd2, 8'h80, 1'b0, 1'b0, 1'b1, 0);
      dir("mul_10_11", 8'h10, 8'h11, 4'd11, MUL_EN ? 8'h10 : 8'h00, 1'b0, 1'b0, MUL_EN, MUL_EN ? W : 0);
      dir("undef_f", 8'h55, 8'hAA, 4'd15, 8'h00, 1'b0, 1'b0, 1'b0, 0);

      // Back-pressure: result held, new request waits.
      out_ready = 1'b0;
      send(8'h10, 8'h20, 4'd0);
      a = 8'h01; b = 8'h02; opcode = 4'd0; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_in_ready", in_ready, 1'b0);
         chk("bp_hold_out_s", out_s, 8'h30);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      vcount = 0;
      @(negedge clk);
      vcount += out_valid;
      @(posedge clk); #1;
      a = 8'd10; b = 8'd0; opcode = 4'd0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         vcount += out_valid;
         @(posedge clk); #1;
         if (i < 3) begin a = 8'(10 + 10 * (i + 1)); b = 8'(i + 1); end
         else in_valid = 1'b0;
      end
      @(negedge clk);
      vcount += out_valid;
      chk("stream_gapless_valid_cycles", vcount, 6);
      @(posedge clk); #1;

      // Randomized traffic.
      rand_rdy = 1'b1;
      for (int n = 0; n < 300; n++) begin
         logic [7:0] ra, rb;
         logic [3:0] rop;
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         ra = ($urandom_range(0, 4) == 0) ? specials[$urandom_range(0, 3)] : 8'($urandom);
         rb = ($urandom_range(0, 4) == 0) ? specials[$urandom_range(0, 3)] : 8'($urandom);
         rop = ($urandom_range(0, 7) == 0) ? 4'd11 : 4'($urandom_range(0, 15));
         send(ra, rb, rop);
      end
      rand_rdy = 1'b0;
      @(posedge clk); #2;
      out_ready = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      chk("drain_empty", sbq.size(), 0);

      // Reset in the middle of a multiply.
      send(8'h10, 8'h11, 4'd11);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      sbq.delete();
      #1;
      chk("midmul_reset_out_valid", out_valid, 1'b0);
      chk("midmul_reset_outputs", {out_s, out_c, out, overflow}, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      dir("post_reset_add", 8'd2, 8'd3, 4'd0, 8'd5, 1'b0, 1'b0, 1'b0, 0);

      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
